decode_stage: RTL
=================

# decode_stage

Second pipeline stage of the RV32I core, directly downstream of the fetch stage. Captures the fetched PC and instruction in an IF/ID pipeline register with stall and flush control. Holds the 32x32 architectural register file written back from WB. Presents decoded register addresses, operand data and the sign-extended immediate to the execute stage.

## Interface
Parameters:
- NOP, 32'h0000_0013, instruction value loaded on reset and on flush (addi x0,x0,0)

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge
- i_rst  in  1  reset, asynchronous, active-low; clears all state immediately when low
- i_pc  in  32  PC of the instruction from fetch
- i_instruct  in  32  instruction word from fetch
- i_stall  in  1  hold the IF/ID register (hazard unit)
- i_flush  in  1  replace IF/ID contents with a bubble (taken branch or jump)
- i_wb_en  in  1  register-file write enable from WB
- i_wb_rd  in  5  write-back destination register
- i_wb_data  in  32  write-back data
- o_pc  out  32  registered PC
- o_instruct  out  32  registered instruction
- o_valid  out  1  registered instruction is real, not a bubble
- o_rs1_addr / o_rs2_addr / o_rd_addr  out  5 each  instruction fields [19:15] / [24:20] / [11:7]
- o_rs1_data / o_rs2_data  out  32 each  operand data
- o_imm  out  32  sign-extended immediate

## Operation
- IF/ID register, at each rising edge, in priority order:
  - i_flush=1: pc←0, instr←NOP, valid←0.
  - else if i_stall=1: hold all three fields.
  - else: pc←i_pc, instr←i_instruct, valid←1.
- Flush has priority over stall when both are high.
- Register file: 32 entries of 32 bits.
  - Write at the rising edge when i_wb_en=1 and i_wb_rd≠0.
  - x0 always reads 0; writes to x0 are dropped.
  - Writes happen regardless of i_stall and i_flush.
- Read ports are combinational from the registered instruction fields.
- Write-through bypass: if i_wb_en=1, i_wb_rd≠0 and i_wb_rd equals a read address, that port returns i_wb_data in the same cycle.
- Immediate, selected by opcode = instr[6:0]; all formats are sign-extended from instr[31]:
  - I-type (0010011, 0000011, 1100111): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Any other opcode, including R-type: 0.
- Address outputs are raw instruction fields, driven even when unused by the format.

## Timing
- Reset (i_rst low), effective immediately without waiting for a clock edge:
  - o_pc=0, o_instruct=NOP, o_valid=0.
  - All registers=0, so o_rs1_data=o_rs2_data=0.
  - o_imm=0, since NOP's imm field is 0.
  - Address outputs = 0.
- Release is synchronous to the next rising edge; the first capture happens on that edge.
- Latency: fetch output at edge N appears on the decode outputs after edge N+1.
- Data and immediate outputs are combinational from IF/ID and register-file state, valid in the same cycle.
- A write at edge N is visible through the normal read path after edge N, and through the bypass before edge N.
- Stall held for k cycles: outputs stay constant for k cycles, except operand data, which may change through write-back.
- Reset asserted mid-operation: IF/ID and the register file clear asynchronously; a coincident write is lost.

## Test plan
- Reset then capture: hold i_rst low, check o_instruct=0x00000013 and o_valid=0. Release, drive i_pc=0x10, i_instruct=0x00500093 (addi x1,x0,5), one edge -> o_pc=0x10, o_rd_addr=1, o_imm=5, o_valid=1.
- Write/read with bypass: wb x3=0xDEADBEEF while the held instruction reads rs1=x3 -> o_rs1_data=0xDEADBEEF in the same cycle and after the edge. wb x0=0x1234 -> x0 reads 0.
- Stall and flush: stall for 3 cycles with changing fetch inputs -> o_pc unchanged. Assert stall and flush together -> o_instruct=NOP, o_valid=0, o_pc=0.
- Immediates, each with a negative case:
  - instruct 0xFE20AE23 (sw, offset -4) -> o_imm=0xFFFFFFFC.
  - 0xFE000EE3 (beq, offset -4) -> 0xFFFFFFFC.
  - 0x123452B7 (lui) -> 0x12345000.
  - 0xFFDFF06F (jal -4) -> 0xFFFFFFFC.
  - 0x002081B3 (add) -> 0.
- Async reset mid-run: write x5=7, then pull i_rst low between edges -> all outputs return to reset values before the next edge, and x5 then reads 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: second stage of the RV32I pipeline.
//   Captures PC/instruction from fetch in the IF/ID register (stall, flush),
//   holds the 32x32 register file written from WB, and presents register
//   addresses, operand data (with WB write-through) and the immediate.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_pc, i_instruct        fetch outputs
//   i_stall, i_flush        hazard control (flush wins)
//   i_wb_en, i_wb_rd, i_wb_data   register-file write port
//   o_pc, o_instruct, o_valid     IF/ID contents
//   o_rs1_addr, o_rs2_addr, o_rd_addr, o_rs1_data, o_rs2_data, o_imm
module decode_stage #(
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instruct,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruct,
  output logic        o_valid,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_imm
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [XLEN-1:0] regs [NREG];
  logic            wb_write;

  // Writes to x0 are dropped here so x0 never holds anything but zero.
  assign wb_write = i_wb_en && (i_wb_rd != AW'(0));

  // IF/ID pipeline register; flush has priority over stall.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_pc       <= '0;
      o_instruct <= NOP;
      o_valid    <= 1'b0;
    end else if (i_flush) begin
      o_pc       <= '0;
      o_instruct <= NOP;
      o_valid    <= 1'b0;
    end else if (!i_stall) begin
      o_pc       <= i_pc;
      o_instruct <= i_instruct;
      o_valid    <= 1'b1;
    end
  end

  // Register file; WB writes are independent of stall/flush.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[i_wb_rd] <= i_wb_data;
    end
  end

  assign o_rs1_addr = o_instruct[19:15];
  assign o_rs2_addr = o_instruct[24:20];
  assign o_rd_addr  = o_instruct[11:7];

  // Read ports with same-cycle write-through from WB.
  always_comb begin
    o_rs1_data = '0;
    if (o_rs1_addr != AW'(0)) begin
      if (wb_write && (i_wb_rd == o_rs1_addr)) o_rs1_data = i_wb_data;
      else                                     o_rs1_data = regs[o_rs1_addr];
    end
  end

  always_comb begin
    o_rs2_data = '0;
    if (o_rs2_addr != AW'(0)) begin
      if (wb_write && (i_wb_rd == o_rs2_addr)) o_rs2_data = i_wb_data;
      else                                     o_rs2_data = regs[o_rs2_addr];
    end
  end

  // Immediate generation by opcode; unknown opcodes (and R-type) give 0.
  always_comb begin
    o_imm = '0;
    case (o_instruct[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        o_imm = {{20{o_instruct[31]}}, o_instruct[31:20]};
      OP_STORE:
        o_imm = {{20{o_instruct[31]}}, o_instruct[31:25], o_instruct[11:7]};
      OP_BRANCH:
        o_imm = {{19{o_instruct[31]}}, o_instruct[31], o_instruct[7],
                 o_instruct[30:25], o_instruct[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        o_imm = {o_instruct[31:12], 12'b0};
      OP_JAL:
        o_imm = {{11{o_instruct[31]}}, o_instruct[31], o_instruct[19:12],
                 o_instruct[20], o_instruct[30:21], 1'b0};
      default:
        o_imm = '0;
    endcase
  end

endmodule
